spi_flash_arbiter: RTL
======================

# spi_flash_arbiter

Two-client arbiter that shares the single SPI-master user interface (enable/idle/tx/rx strobes toward the flash) between requesters such as the boot-time flash-to-SPRAM loader and a runtime save-data engine. Grants are round-robin and held per session: an owner may issue any number of back-to-back SPI transactions, for example reset then read, without losing the bus. The block sits between the clients and the SPI master and is transparent to the SPI master.

## Interface
- `GRANT_TIMEOUT`, 16'd2000: cycles a granted client may sit without pulsing enable before the grant is revoked; 0 disables the timeout.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `c_req`  in  [1:0]  per-client session request, level.
- `c_gnt`  out  [1:0]  per-client grant, registered, one-hot or zero.
- `c_enable`  in  [1:0]  per-client transaction start pulse.
- `c_idle`  out  [1:0]  per-client view of `spi_idle`.
- `c_tx_len`  in  [1:0][7:0]  per-client TX length.
- `c_tx_data`  in  [1:0][7:0]  per-client TX data.
- `c_tx_fetch`  out  [1:0]  per-client TX fetch strobe.
- `c_rx_len`  in  [1:0][23:0]  per-client RX length.
- `c_rx_store`  out  [1:0]  per-client RX store strobe.
- `c_rx_data`  out  8  RX data, broadcast to both clients.
- `spi_enable`, `spi_tx_len`, `spi_tx_data`, `spi_rx_len`  out  1/8/8/24  toward the SPI master.
- `spi_idle`, `spi_tx_fetch`, `spi_rx_store`, `spi_rx_data`  in  1/1/1/8  from the SPI master.
- `busy`  out  1  high while any grant is held.
- `owner`  out  1  index of the current or last owner.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: S_IDLE, S_GRANTED, S_ACTIVE.
- **S_IDLE**
  - Entry requires `spi_idle`=1.
  - If any `c_req` is high, pick a winner, set `c_gnt[w]`, set `owner`=w, and go to S_GRANTED.
  - Round-robin rule: if both clients request, the winner is the client other than the last owner.
- **S_GRANTED**
  - `c_enable[owner]`=1 with `spi_idle`=1: drive `spi_enable`=1 for that cycle and go to S_ACTIVE.
  - `c_req[owner]`=0: clear the grant and go to S_IDLE.
  - Timeout counter reaches `GRANT_TIMEOUT` (when nonzero): clear the grant, pulse `timeout`, and go to S_IDLE.
- **S_ACTIVE**
  - The transaction is in flight. A rising edge of `spi_idle` (registered delay compare) returns the FSM to S_GRANTED.
  - The grant is never revoked in this state, including on timeout and when req drops.
- Datapath mux is combinational on registered `owner`/`c_gnt`:
  - `spi_tx_len`, `spi_tx_data`, `spi_rx_len` select the owner's inputs; they are 0 when no grant is held.
  - `c_tx_fetch[i]` = `spi_tx_fetch & c_gnt[i]`.
  - `c_rx_store[i]` = `spi_rx_store & c_gnt[i]`.
  - `c_idle[i]` = `spi_idle & c_gnt[i]`. A non-owner always sees idle=0, so it cannot falsely detect an idle rise.
- `spi_enable` is asserted only from S_GRANTED as described above. Enables from a non-owner, or from the owner while in S_ACTIVE, are ignored and produce no effect.
- Timeout counter: 16 bits, cleared on entry to S_GRANTED and on every accepted enable, and increments only in S_GRANTED.

## Timing
- Reset values:
  - `c_gnt`=0, `busy`=0, `owner`=1, so client 0 wins the first tie.
  - `timeout`=0, `spi_enable`=0, all mux outputs 0, state S_IDLE, counter 0.
- Latency:
  - Req to grant: `c_req` seen at edge N gives `c_gnt` high after edge N+1.
  - Enable pass-through: zero latency. `spi_enable` equals the owner's `c_enable` in the same cycle, gated by state.
  - Fetch/store routing: zero latency, so the SPI master's fetch-to-data timing is preserved.
- Enable in the same cycle the grant rises: ignored, because `c_gnt` must already be high at the sampling edge.
- Simultaneous req drop and enable in S_GRANTED: enable wins and the FSM goes to S_ACTIVE. The grant is released after that transaction's idle rise if req is still low.
- Release back-to-back: after a grant clears, the FSM spends one cycle in S_IDLE before any new grant, so `c_gnt` is never high for both clients and never switches directly from one client to the other.
- Reset mid-transaction:
  - All outputs return to reset values on the next edge.
  - The SPI master shares `reset`.

## Structure
- Package `spi_arb_pkg`: state enum `s_arb` (S_IDLE, S_GRANTED, S_ACTIVE) and `NUM_CLIENTS`=2.
- Sub-module `spi_arb_rr`: combinational round-robin picker, taking inputs req[1:0] and last owner and producing the winner and a valid flag.
- Everything else lives in one always_ff block for the FSM and counter, plus an always_comb block for the mux.

## Test plan
- **Single client 0:** req=1, gnt at +1. Two transactions (tx_len=1 0x66, then tx_len=4 with rx_len=16) complete with the grant held throughout; req=0 then clears gnt and sets busy=0.
- **Simultaneous req=2'b11 after reset:** client 0 granted first. When it releases, client 1 is granted exactly 2 cycles later.
- **Isolation:** during client 0's read, client 1 pulses enable and sees `c_idle[1]`=0, `c_rx_store[1]`=0 and `c_tx_fetch[1]`=0. `spi_enable` stays 0 apart from client 0's enable pulses.
- **Timeout:** with GRANT_TIMEOUT=16, client 1 is granted but never enables. Grant clears after 16 cycles in S_GRANTED, `timeout` pulses once, and client 0's pending req is granted next.
- **req drop mid-transfer:** client 0 drops req during rx_len=256. The grant holds until the idle rise, all 256 stores go to client 0, then the grant clears.
- **Reset during S_ACTIVE:** `reset`=1 for 1 cycle leaves all outputs at reset values. A subsequent req from either client is granted normally.

Source files
------------

// File: rtl/spi_flash_arbiter_pkg.sv
// ============================================================================
// Module   : spi_arb_pkg
// Brief    : Shared state encoding and client count for the SPI flash arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_arb_pkg;

    localparam int NUM_CLIENTS = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_ACTIVE  = 2'd2
    } s_arb;

endpackage

`default_nettype wire

// File: rtl/spi_arb_rr.sv
// ============================================================================
// Module   : spi_arb_rr
// Brief    : Combinational two-way round-robin picker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_arb_rr
    import spi_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic                   i_last_owner,
    output logic                   o_winner,
    output logic                   o_valid
);

    always_comb begin
        o_valid = |i_req;
        // On a tie the client that did not own the bus last time goes first.
        if (i_req[0] && i_req[1]) begin
            o_winner = ~i_last_owner;
        end else begin
            o_winner = i_req[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_flash_arbiter.sv
// ============================================================================
// Module   : spi_flash_arbiter
// Brief    : Session-held round-robin arbiter sharing one SPI master user port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter logic [15:0] GRANT_TIMEOUT = 16'd2000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CLIENTS-1:0]       c_req,
    output logic [NUM_CLIENTS-1:0]       c_gnt,
    input  logic [NUM_CLIENTS-1:0]       c_enable,
    output logic [NUM_CLIENTS-1:0]       c_idle,
    input  logic [NUM_CLIENTS-1:0][7:0]  c_tx_len,
    input  logic [NUM_CLIENTS-1:0][7:0]  c_tx_data,
    output logic [NUM_CLIENTS-1:0]       c_tx_fetch,
    input  logic [NUM_CLIENTS-1:0][23:0] c_rx_len,
    output logic [NUM_CLIENTS-1:0]       c_rx_store,
    output logic [7:0]                   c_rx_data,
    output logic                         spi_enable,
    output logic [7:0]                   spi_tx_len,
    output logic [7:0]                   spi_tx_data,
    output logic [23:0]                  spi_rx_len,
    input  logic                         spi_idle,
    input  logic                         spi_tx_fetch,
    input  logic                         spi_rx_store,
    input  logic [7:0]                   spi_rx_data,
    output logic                         busy,
    output logic                         owner,
    output logic                         timeout
);

    s_arb                   r_state;
    logic [NUM_CLIENTS-1:0] r_gnt;
    logic                   r_owner;
    logic                   r_busy;
    logic                   r_timeout;
    logic                   r_idle_d;
    logic [15:0]            r_cnt;

    logic                   w_winner;
    logic                   w_valid;
    logic                   w_accept;
    logic                   w_idle_rise;
    logic                   w_expire;
    logic [15:0]            w_cnt_next;

    spi_arb_rr u_rr (
        .i_req        (c_req),
        .i_last_owner (r_owner),
        .o_winner     (w_winner),
        .o_valid      (w_valid)
    );

    // Only an owner sitting in S_GRANTED with an idle master may start a transaction.
    assign w_accept    = (r_state == S_GRANTED) && c_enable[r_owner] && spi_idle;
    assign w_idle_rise = spi_idle && !r_idle_d;
    assign w_cnt_next  = r_cnt + 16'd1;
    assign w_expire    = (GRANT_TIMEOUT != 16'd0) && (w_cnt_next == GRANT_TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_owner   <= 1'b1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_idle_d  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_idle_d  <= spi_idle;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid && spi_idle) begin
                        r_gnt   <= 2'b01 << w_winner;
                        r_owner <= w_winner;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_GRANTED;
                    end
                end
                S_GRANTED: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_state <= S_ACTIVE;
                    end else if (!c_req[r_owner] || w_expire) begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= c_req[r_owner];
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_ACTIVE: begin
                    // Grant is pinned until the master reports completion.
                    if (w_idle_rise) begin
                        r_cnt   <= '0;
                        r_state <= S_GRANTED;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        spi_enable  = w_accept;
        spi_tx_len  = '0;
        spi_tx_data = '0;
        spi_rx_len  = '0;
        if (r_busy) begin
            spi_tx_len  = c_tx_len[r_owner];
            spi_tx_data = c_tx_data[r_owner];
            spi_rx_len  = c_rx_len[r_owner];
        end
        // Non-owners never see idle, so they cannot mistake another session's completion for their own.
        c_idle     = {NUM_CLIENTS{spi_idle}} & r_gnt;
        c_tx_fetch = {NUM_CLIENTS{spi_tx_fetch}} & r_gnt;
        c_rx_store = {NUM_CLIENTS{spi_rx_store}} & r_gnt;
        c_rx_data  = spi_rx_data;
    end

    assign c_gnt   = r_gnt;
    assign busy    = r_busy;
    assign owner   = r_owner;
    assign timeout = r_timeout;

endmodule

`default_nettype wire
